// File: rtl/serial_adder.sv
// Bit-serial adder: a single full-adder cell is reused over WIDTH cycles, LSB first,
// with a start/busy/done handshake and registered sum, carry-out and signed overflow.
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } state_t;

   state_t           state, state_next;
   logic [WIDTH-1:0] a_sh, a_sh_next;
   logic [WIDTH-1:0] b_sh, b_sh_next;
   logic             carry, carry_next;
   logic [CW-1:0]    cnt, cnt_next;
   logic [WIDTH-1:0] sum_next;
   logic             cout_next, ovf_next, busy_next, done_next;

   logic             s_bit, c_bit, last_bit;
   logic [WIDTH-1:0] sum_shift;

   assign s_bit    = a_sh[0] ^ b_sh[0] ^ carry;
   assign c_bit    = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
   assign last_bit = (cnt == CW'(WIDTH - 1));

   // New bits enter at the MSB so the LSB-first result ends up in place.
   generate
      if (WIDTH == 1) begin : g_one
         assign sum_shift = s_bit;
      end else begin : g_many
         assign sum_shift = {s_bit, sum[WIDTH-1:1]};
      end
   endgenerate

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         a_sh  <= '0;
         b_sh  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_next;
         a_sh  <= a_sh_next;
         b_sh  <= b_sh_next;
         carry <= carry_next;
         cnt   <= cnt_next;
         sum   <= sum_next;
         cout  <= cout_next;
         ovf   <= ovf_next;
         busy  <= busy_next;
         done  <= done_next;
      end
   end

   always_comb begin
      state_next = state;
      a_sh_next  = a_sh;
      b_sh_next  = b_sh;
      carry_next = carry;
      cnt_next   = cnt;
      sum_next   = sum;
      cout_next  = cout;
      ovf_next   = ovf;
      busy_next  = busy;
      done_next  = done;

      case (state)
         IDLE, FIN: begin
            state_next = IDLE;
            busy_next  = 1'b0;
            done_next  = 1'b0;
            if (start) begin
               state_next = RUN;
               a_sh_next  = a;
               b_sh_next  = b;
               carry_next = cin;
               cnt_next   = '0;
               sum_next   = '0;
               busy_next  = 1'b1;
            end
         end
         RUN: begin
            sum_next   = sum_shift;
            carry_next = c_bit;
            a_sh_next  = a_sh >> 1;
            b_sh_next  = b_sh >> 1;
            cnt_next   = cnt + CW'(1);
            if (last_bit) begin
               // carry still holds the carry into the MSB on this edge
               cout_next  = c_bit;
               ovf_next   = carry ^ c_bit;
               state_next = FIN;
               busy_next  = 1'b0;
               done_next  = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            busy_next  = 1'b0;
            done_next  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_serial_adder.sv
// Directed and swept checks of serial_adder at WIDTH=8 and WIDTH=1.
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start8, cin8, busy8, done8, cout8, ovf8;
   logic [7:0] a8, b8, sum8;
   logic       start1, cin1, busy1, done1, cout1, ovf1;
   logic [0:0] a1, b1, sum1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8)
   );

   serial_adder #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive one accepted start; operands are scrambled afterwards to prove they were captured.
   task automatic accept8(input logic [7:0] a, input logic [7:0] b, input logic c);
      start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
      tick();
      start8 = 1'b0; a8 = ~a; b8 = ~b; cin8 = ~c;
   endtask

   task automatic accept1(input logic [0:0] a, input logic [0:0] b, input logic c);
      start1 = 1'b1; a1 = a; b1 = b; cin1 = c;
      tick();
      start1 = 1'b0; a1 = ~a; b1 = ~b; cin1 = ~c;
   endtask

   task automatic wait_done8(output int cyc);
      cyc = 0;
      do begin
         tick();
         cyc++;
      end while (!done8 && cyc < 40);
   endtask

   task automatic wait_done1(output int cyc);
      cyc = 0;
      do begin
         tick();
         cyc++;
      end while (!done1 && cyc < 40);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start8 = 1'b0; a8 = 8'h5A; b8 = 8'hA5; cin8 = 1'b1;
      start1 = 1'b0; a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1;
      #12;
      checks++;
      if ({busy8, done8, sum8, cout8, ovf8} !== 12'h000) begin
         errors++;
         $display("FAIL reset8: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                  busy8, done8, sum8, cout8, ovf8);
      end
      checks++;
      if ({busy1, done1, sum1, cout1, ovf1} !== 5'h00) begin
         errors++;
         $display("FAIL reset1: got busy=%b done=%b sum=%b cout=%b ovf=%b, want all 0",
                  busy1, done1, sum1, cout1, ovf1);
      end
      rst_n = 1'b1;
      tick();
      tick();
      checks++;
      if ({busy8, done8, sum8, cout8, ovf8} !== 12'h000) begin
         errors++;
         $display("FAIL idle_after_reset: got busy=%b done=%b sum=%h, want idle zeros",
                  busy8, done8, sum8);
      end
      $display("reset: busy=%b done=%b sum=%h", busy8, done8, sum8);
   endtask

   task automatic test_basic();
      int cyc;
      accept8(8'h3C, 8'h0F, 1'b0);
      checks++;
      if (busy8 !== 1'b1 || done8 !== 1'b0 || sum8 !== 8'h00) begin
         errors++;
         $display("FAIL basic_accept: got busy=%b done=%b sum=%h, want busy=1 done=0 sum=00",
                  busy8, done8, sum8);
      end
      wait_done8(cyc);
      checks++;
      if (cyc !== 8 || done8 !== 1'b1 || busy8 !== 1'b0) begin
         errors++;
         $display("FAIL basic_latency: got %0d cycles done=%b busy=%b, want 8 cycles done=1 busy=0",
                  cyc, done8, busy8);
      end
      checks++;
      if ({cout8, sum8, ovf8} !== {1'b0, 8'h4B, 1'b0}) begin
         errors++;
         $display("FAIL basic_result: got cout=%b sum=%h ovf=%b, want cout=0 sum=4b ovf=0",
                  cout8, sum8, ovf8);
      end
      tick();
      checks++;
      if (done8 !== 1'b0 || busy8 !== 1'b0 || sum8 !== 8'h4B) begin
         errors++;
         $display("FAIL basic_done_pulse: got done=%b busy=%b sum=%h, want done=0 busy=0 sum=4b",
                  done8, busy8, sum8);
      end
      $display("basic: 3c+0f+0 -> sum=%h cout=%b ovf=%b in %0d cycles", sum8, cout8, ovf8, cyc);
   endtask

   task automatic test_overflow();
      int cyc;
      accept8(8'hFF, 8'h01, 1'b0);
      wait_done8(cyc);
      checks++;
      if (done8 !== 1'b1 || {cout8, sum8, ovf8} !== {1'b1, 8'h00, 1'b0}) begin
         errors++;
         $display("FAIL carry_out: got done=%b cout=%b sum=%h ovf=%b, want 1 1 00 0",
                  done8, cout8, sum8, ovf8);
      end
      $display("overflow: ff+01 -> sum=%h cout=%b ovf=%b", sum8, cout8, ovf8);
      tick();
      accept8(8'h7F, 8'h01, 1'b0);
      wait_done8(cyc);
      checks++;
      if (done8 !== 1'b1 || {cout8, sum8, ovf8} !== {1'b0, 8'h80, 1'b1}) begin
         errors++;
         $display("FAIL signed_ovf: got done=%b cout=%b sum=%h ovf=%b, want 1 0 80 1",
                  done8, cout8, sum8, ovf8);
      end
      $display("overflow: 7f+01 -> sum=%h cout=%b ovf=%b", sum8, cout8, ovf8);
      tick();
   endtask

   task automatic test_back_to_back();
      int cyc;
      accept8(8'h80, 8'h80, 1'b1);
      wait_done8(cyc);
      checks++;
      if (done8 !== 1'b1 || {cout8, sum8, ovf8} !== {1'b1, 8'h01, 1'b1}) begin
         errors++;
         $display("FAIL b2b_first: got done=%b cout=%b sum=%h ovf=%b, want 1 1 01 1",
                  done8, cout8, sum8, ovf8);
      end
      $display("b2b: 80+80+1 -> sum=%h cout=%b ovf=%b", sum8, cout8, ovf8);
      // start held high during the done cycle
      accept8(8'h01, 8'h02, 1'b0);
      checks++;
      if (busy8 !== 1'b1 || done8 !== 1'b0 || sum8 !== 8'h00) begin
         errors++;
         $display("FAIL b2b_accept_in_fin: got busy=%b done=%b sum=%h, want busy=1 done=0 sum=00",
                  busy8, done8, sum8);
      end
      wait_done8(cyc);
      checks++;
      if (cyc !== 8 || done8 !== 1'b1 || {cout8, sum8, ovf8} !== {1'b0, 8'h03, 1'b0}) begin
         errors++;
         $display("FAIL b2b_second: got %0d cycles done=%b cout=%b sum=%h ovf=%b, want 8 1 0 03 0",
                  cyc, done8, cout8, sum8, ovf8);
      end
      $display("b2b: 01+02+0 -> sum=%h cout=%b ovf=%b in %0d cycles", sum8, cout8, ovf8, cyc);
      tick();
   endtask

   task automatic test_ignore_start();
      int busy_bad = 0;
      int extra_done = 0;
      accept8(8'h10, 8'h20, 1'b0);
      if (busy8 !== 1'b1) busy_bad++;
      for (int k = 1; k <= 7; k++) begin
         if (k == 3) begin
            start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
         end
         tick();
         start8 = 1'b0;
         if (busy8 !== 1'b1 || done8 !== 1'b0) busy_bad++;
      end
      checks++;
      if (busy_bad !== 0) begin
         errors++;
         $display("FAIL ignore_busy: got %0d cycles with busy low or early done, want 0", busy_bad);
      end
      tick();
      checks++;
      if (done8 !== 1'b1 || {cout8, sum8, ovf8} !== {1'b0, 8'h30, 1'b0}) begin
         errors++;
         $display("FAIL ignore_result: got done=%b cout=%b sum=%h ovf=%b, want 1 0 30 0",
                  done8, cout8, sum8, ovf8);
      end
      for (int k = 0; k < 12; k++) begin
         tick();
         if (done8 !== 1'b0 || busy8 !== 1'b0) extra_done++;
      end
      checks++;
      if (extra_done !== 0) begin
         errors++;
         $display("FAIL ignore_single_done: got %0d cycles of extra activity, want 0", extra_done);
      end
      $display("ignore: 10+20 with mid-run start -> sum=%h", sum8);
   endtask

   task automatic test_reset_abort();
      int cyc;
      int stray = 0;
      accept8(8'hAA, 8'h55, 1'b0);
      for (int k = 0; k < 4; k++) tick();
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy8, done8, sum8, cout8, ovf8} !== 12'h000) begin
         errors++;
         $display("FAIL abort_async: got busy=%b done=%b sum=%h cout=%b ovf=%b, want all 0",
                  busy8, done8, sum8, cout8, ovf8);
      end
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (done8 !== 1'b0 || busy8 !== 1'b0) stray++;
      end
      checks++;
      if (stray !== 0) begin
         errors++;
         $display("FAIL abort_no_done: got %0d active cycles after abort, want 0", stray);
      end
      accept8(8'hAA, 8'h55, 1'b0);
      wait_done8(cyc);
      checks++;
      if (done8 !== 1'b1 || {cout8, sum8, ovf8} !== {1'b0, 8'hFF, 1'b0}) begin
         errors++;
         $display("FAIL abort_restart: got done=%b cout=%b sum=%h ovf=%b, want 1 0 ff 0",
                  done8, cout8, sum8, ovf8);
      end
      $display("abort: restart aa+55 -> sum=%h cout=%b", sum8, cout8);
      tick();
   endtask

   task automatic test_random8();
      int cyc;
      logic [7:0] ra, rb;
      logic       rc, exp_ovf;
      logic [8:0] full;
      for (int n = 0; n < 1000; n++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rc = 1'($urandom);
         full = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
         exp_ovf = (ra[7] == rb[7]) && (full[7] != ra[7]);
         accept8(ra, rb, rc);
         wait_done8(cyc);
         checks++;
         if (cyc !== 8 || done8 !== 1'b1 || {cout8, sum8} !== full || ovf8 !== exp_ovf) begin
            errors++;
            $display("FAIL rand8 %h+%h+%b: got %0d cycles done=%b {cout,sum}=%h ovf=%b, want 8 1 %h %b",
                     ra, rb, rc, cyc, done8, {cout8, sum8}, ovf8, full, exp_ovf);
         end
         $display("rand8 %h+%h+%b -> %h ovf=%b", ra, rb, rc, {cout8, sum8}, ovf8);
      end
   endtask

   task automatic test_random1();
      int cyc;
      logic [0:0] ra, rb;
      logic       rc, exp_ovf;
      logic [1:0] full;
      for (int n = 0; n < 1000; n++) begin
         ra = 1'($urandom);
         rb = 1'($urandom);
         rc = 1'($urandom);
         full = {1'b0, ra} + {1'b0, rb} + {1'b0, rc};
         exp_ovf = (ra[0] == rb[0]) && (full[0] != ra[0]);
         accept1(ra, rb, rc);
         wait_done1(cyc);
         checks++;
         if (cyc !== 1 || done1 !== 1'b1 || {cout1, sum1} !== full || ovf1 !== exp_ovf) begin
            errors++;
            $display("FAIL rand1 %b+%b+%b: got %0d cycles done=%b {cout,sum}=%b ovf=%b, want 1 1 %b %b",
                     ra, rb, rc, cyc, done1, {cout1, sum1}, ovf1, full, exp_ovf);
         end
         $display("rand1 %b+%b+%b -> %b ovf=%b", ra, rb, rc, {cout1, sum1}, ovf1);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_overflow();
      test_back_to_back();
      test_ignore_start();
      test_reset_abort();
      test_random8();
      test_random1();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
